centroid_marker: RTL and testbench

Downstream overlay stage for the skin-colour tracker. Consumes the centroid coordinates (x, y) produced by the centroid stage together with the original video stream, and paints a cross-shaped marker centred on the centroid into the outgoing RGB pixels. Coordinates are captured once per frame so the marker never tears. All video and sync signals pass through a fixed 2-cycle pipeline.

---
 rtl/centroid_marker.sv | 112 +++++++++++
 tb/tb_centroid_marker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/centroid_marker.sv
// Paints a cross-shaped marker centred on the per-frame captured centroid into
// the video stream; video, de and syncs all pass through a fixed 2-stage pipeline.
module centroid_marker #(
  parameter logic [9:0]  IMG_W      = 10'd720,
  parameter logic [9:0]  IMG_H      = 10'd576,
  parameter logic [9:0]  ARM        = 10'd10,
  parameter logic [9:0]  THICK      = 10'd1,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        marker_en,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out
);

  logic [9:0]  cnt_w, cnt_h;
  logic [9:0]  mx, my;
  logic        en_l;
  logic        vsync_prev;

  logic        rise;
  logic [9:0]  cur_mx, cur_my;
  logic        cur_en;
  logic signed [10:0] diff_w, diff_h;
  logic [10:0] abs_w, abs_h;

  logic [23:0] pixel_s1;
  logic        de_s1, hsync_s1, vsync_s1, en_s1;
  logic [10:0] dx_s1, dy_s1;
  logic        hit;

  // On the frame-start cycle the fresh coordinates bypass the capture
  // registers so the very first pixel of the frame already uses them.
  assign rise   = vsync & ~vsync_prev;
  assign cur_mx = rise ? x : mx;
  assign cur_my = rise ? y : my;
  assign cur_en = rise ? marker_en : en_l;

  assign diff_w = $signed({1'b0, cnt_w}) - $signed({1'b0, cur_mx});
  assign diff_h = $signed({1'b0, cnt_h}) - $signed({1'b0, cur_my});
  assign abs_w  = diff_w[10] ? 11'(-diff_w) : 11'(diff_w);
  assign abs_h  = diff_h[10] ? 11'(-diff_h) : 11'(diff_h);

  assign hit = en_s1 & de_s1 &
               (((dx_s1 <= {1'b0, THICK}) & (dy_s1 <= {1'b0, ARM})) |
                ((dy_s1 <= {1'b0, THICK}) & (dx_s1 <= {1'b0, ARM})));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_w      <= '0;
      cnt_h      <= '0;
      mx         <= '0;
      my         <= '0;
      en_l       <= 1'b0;
      vsync_prev <= 1'b0;
      pixel_s1   <= '0;
      de_s1      <= 1'b0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      en_s1      <= 1'b0;
      dx_s1      <= '0;
      dy_s1      <= '0;
      de_out     <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      pixel_out  <= '0;
    end else if (ce) begin
      vsync_prev <= vsync;
      if (rise) begin
        mx   <= x;
        my   <= y;
        en_l <= marker_en;
      end

      if (!vsync) begin
        cnt_w <= '0;
        cnt_h <= '0;
      end else if (de) begin
        if (cnt_w == IMG_W - 10'd1) begin
          cnt_w <= '0;
          cnt_h <= (cnt_h == IMG_H - 10'd1) ? 10'd0 : cnt_h + 10'd1;
        end else begin
          cnt_w <= cnt_w + 10'd1;
        end
      end

      pixel_s1 <= pixel_in;
      de_s1    <= de;
      hsync_s1 <= hsync;
      vsync_s1 <= vsync;
      en_s1    <= cur_en;
      dx_s1    <= abs_w;
      dy_s1    <= abs_h;

      de_out    <= de_s1;
      hsync_out <= hsync_s1;
      vsync_out <= vsync_s1;
      pixel_out <= hit ? MARK_COLOR : pixel_s1;
    end
  end

endmodule

// File: tb/tb_centroid_marker.sv
// Randomised bench for centroid_marker on a reduced 40x30 frame, checked every
// cycle against a geometric reference model plus per-frame marker pixel counts.
module tb_centroid_marker;

  localparam int W = 40;
  localparam int H = 30;
  localparam int ARM_P = 10;
  localparam int THICK_P = 1;
  localparam logic [23:0] RED = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst, ce, de, hsync, vsync, marker_en;
  logic [23:0] pixel_in;
  logic [9:0]  x, y;
  logic        de_out, hsync_out, vsync_out;
  logic [23:0] pixel_out;

  centroid_marker #(
    .IMG_W(10'(W)), .IMG_H(10'(H)), .ARM(10'(ARM_P)), .THICK(10'(THICK_P)),
    .MARK_COLOR(RED)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .de(de), .hsync(hsync), .vsync(vsync),
    .pixel_in(pixel_in), .x(x), .y(y), .marker_en(marker_en),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int red_cnt = 0;
  int ce_mode = 0;
  bit tog = 1'b0;
  logic [23:0] ramp = 24'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame position, per-frame captured centroid, one-slot delay
  int m_cw = 0, m_ch = 0, m_mx = 0, m_my = 0;
  bit m_en = 0, m_pv = 0;
  logic [26:0] m_hold = '0, m_out = '0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    bit adv;
    adv = 1'b0;
    if (rst) begin
      m_cw = 0; m_ch = 0; m_mx = 0; m_my = 0; m_en = 0; m_pv = 0;
      m_hold = '0; m_out = '0;
    end else if (ce) begin
      int ddx, ddy;
      bit is_hit;
      adv = 1'b1;
      if (vsync && !m_pv) begin
        m_mx = int'(x); m_my = int'(y); m_en = marker_en;
      end
      m_pv = vsync;
      ddx = iabs(m_cw - m_mx);
      ddy = iabs(m_ch - m_my);
      is_hit = m_en && de && ((ddx <= THICK_P && ddy <= ARM_P) || (ddy <= THICK_P && ddx <= ARM_P));
      m_out  = m_hold;
      m_hold = {de, hsync, vsync, is_hit ? RED : pixel_in};
      if (!vsync) begin
        m_cw = 0; m_ch = 0;
      end else if (de) begin
        if (m_cw == W - 1) begin
          m_cw = 0;
          m_ch = (m_ch == H - 1) ? 0 : m_ch + 1;
        end else begin
          m_cw = m_cw + 1;
        end
      end
    end
    #1;
    check("cycle_out", 64'({de_out, hsync_out, vsync_out, pixel_out}), 64'(m_out));
    if (adv && de_out && pixel_out == RED) red_cnt++;
  end

  function automatic bit pick_ce();
    case (ce_mode)
      0: return 1'b1;
      1: begin tog = ~tog; return tog; end
      default: return ($urandom_range(0, 2) != 0);
    endcase
  endfunction

  // Holds the current inputs until an enabled edge consumes them
  task automatic step();
    bit c;
    do begin
      c = pick_ce();
      ce = c;
      @(negedge clk);
    end while (!c);
  endtask

  task automatic frame(input int fx, input int fy, input bit fen, input int chg_line,
                       input int new_x, input bit use_ramp, input int rst_line);
    vsync = 0; de = 0; hsync = 0; pixel_in = '0;
    x = 10'(fx); y = 10'(fy); marker_en = fen;
    repeat (12) step();
    vsync = 1;
    for (int ln = 0; ln < H; ln++) begin
      if (ln == chg_line) begin
        x = 10'(new_x);
        marker_en = ~fen;
      end
      if (ln == rst_line) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_mid_zero", 64'({de_out, hsync_out, vsync_out, pixel_out}), 64'd0);
      end
      for (int c = 0; c < W; c++) begin
        de = 1;
        if (use_ramp) begin
          pixel_in = ramp;
          ramp = ramp + 24'd2;
        end else begin
          pixel_in = 24'($urandom) | 24'd1;
        end
        step();
      end
      de = 0; pixel_in = '0;
      for (int h = 0; h < 8; h++) begin
        hsync = (h >= 2 && h < 6);
        step();
      end
      hsync = 0;
    end
    vsync = 0;
    repeat (4) step();
  endtask

  task automatic frame_count(input string name, input int fx, input int fy, input bit fen,
                             input int chg_line, input int new_x, input bit use_ramp,
                             input int expected);
    red_cnt = 0;
    frame(fx, fy, fen, chg_line, new_x, use_ramp, -1);
    check(name, 64'(red_cnt), 64'(expected));
  endtask

  initial begin
    rst = 1; ce = 0; de = 0; hsync = 0; vsync = 0; pixel_in = '0;
    x = '0; y = '0; marker_en = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_state", 64'({de_out, hsync_out, vsync_out, pixel_out}), 64'd0);

    ce_mode = 0;
    frame_count("pass_through", 20, 15, 0, -1, 0, 1, 0);
    frame_count("centre", 20, 15, 1, -1, 0, 0, 117);
    frame_count("corner", 0, 0, 1, -1, 0, 0, 40);
    frame_count("far_corner", W - 1, H - 1, 1, -1, 0, 0, 40);
    // mid-frame x and enable changes must wait for the next frame start
    frame_count("midframe_old", 10, 15, 1, 20, 30, 0, 117);
    frame_count("midframe_new", 30, 15, 1, -1, 0, 0, 114);

    ce_mode = 1;
    frame_count("ce_toggle", 20, 15, 1, -1, 0, 0, 117);
    ce_mode = 2;
    frame_count("ce_random", 20, 15, 1, -1, 0, 1, 117);

    ce_mode = 0;
    red_cnt = 0;
    frame(20, 15, 1, -1, 0, 0, 10);
    frame_count("after_reset", 20, 15, 1, -1, 0, 0, 117);

    ce_mode = 2;
    for (int i = 0; i < 4; i++) begin
      red_cnt = 0;
      frame($urandom_range(0, 45), $urandom_range(0, 35), 1'($urandom_range(0, 1)),
            $urandom_range(0, H - 1), $urandom_range(0, 45), 0,
            (i == 2) ? $urandom_range(1, H - 1) : -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
